instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Reverse of the control-unit decode path: takes symbolic instruction requests (op, rs, rt, rd, imm), encodes them into
//  32-bit MIPS words for the supported subset (add/sub/and/or/slt/addi/lw/sw/beq), and buffers them in a FIFO.
//  Then writes them into instruction memory at sequential addresses. Used by the bench/boot path to load programs.
// PARAMETERS
//  ADDR_W   8   instruction-memory word-address width; address counter wraps at 2**ADDR_W
//  DEPTH    4   encoded-word FIFO depth (power of 2, >=2)
// PORTS
//  clk        in   1       single clock, all state updates on rising edge
//  rst        in   1       synchronous reset, active-high
//  start      in   1       pulse: clear address/error state, enter LOAD
//  finish     in   1       pulse: no more requests; drain FIFO then DONE
//  req_valid  in   1       request valid
//  req_ready  out  1       request accepted when req_valid && req_ready
//  req_op     in   4       0 ADD,1 SUB,2 AND,3 OR,4 SLT,5 ADDI,6 LW,7 SW,8 BEQ,9-15 illegal
//  req_rs     in   5       rs field
//  req_rt     in   5       rt field
//  req_rd     in   5       rd field (R-type only, else ignored)
//  req_imm    in   16      immediate/offset (I-type only, else ignored)
//  im_we      out  1       write strobe to instruction memory (= FIFO not empty, state LOAD/FLUSH)
//  im_ready   in   1       memory accepts write when im_we && im_ready
//  im_addr    out  ADDR_W  word address of current write
//  im_wdata   out  32      encoded instruction word (FIFO head)
//  done       out  1       high in DONE
//  err        out  1       sticky: illegal op seen since last start
//  wrapped    out  1       sticky: address counter wrapped since last start
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, im_addr=0, req_ready=0, im_we=0, done=0, err=0, wrapped=0; im_wdata=0.
//  Encoding: R {6'h00,rs,rt,rd,5'h00,funct}, funct add 20h,sub 22h,and 24h,or 25h,slt 2Ah.
//   I {opcode,rs,rt,imm}, opcode addi 08h, lw 23h, sw 2Bh, beq 04h.
//  FSM: IDLE -start-> LOAD -finish-> FLUSH -FIFO empty-> DONE -start-> LOAD. start has priority over finish.
//   start in any state: FIFO flushed, im_addr=0, err/wrapped cleared, next state LOAD.
//  req_ready = (state==LOAD) && !full; a full FIFO that pops this cycle does not raise req_ready.
//  Accepted legal request: encoded and pushed the same edge. First im_we is the next cycle (latency 1).
//  Accepted illegal op: consumed (handshake completes), not pushed, err set.
//  Write: on im_we && im_ready, pop FIFO and im_addr += 1 mod 2**ADDR_W. Addr all-ones -> 0 sets wrapped.
//   Loading continues after wrap.
//  im_we low: im_addr/im_wdata hold. im_wdata/im_addr stable while im_we && !im_ready.
//  Simultaneous push and pop: occupancy unchanged, order preserved.
//  finish in IDLE/FLUSH/DONE ignored. Requests outside LOAD are not accepted.
//  rst mid-operation: everything returns to reset values next edge; buffered words discarded.
// CONFIGURATION
//  ENC_HALT_APPEND_EN defined: on finish in LOAD, one halt word 32'h1000FFFF (beq $0,$0,-1) is pushed behind the last request.
//   If the FIFO is full, it is pushed when space frees, before leaving FLUSH. DONE is only reached after it is written.
//  Not defined: no extra word; FLUSH writes only requested instructions.
// TESTING
//  rst, start, ADD rs=1 rt=2 rd=3 -> im_we next cycle, im_addr=0, im_wdata=32'h00221820.
//  ADDI rs0 rt1 imm5, LW rs1 rt2 imm4, SW rs1 rt2 imm8, BEQ rs1 rt2 immFFFE back-to-back with im_ready=1:
//   -> 20010005 @0, 8C220004 @1, AC220008 @2, 1022FFFE @3.
//  im_ready=0 for 10 cycles while pushing: req_ready drops after DEPTH accepts; words held stable.
//   Release -> all DEPTH words written in order, addresses 0..DEPTH-1.
//  req_op=9 accepted -> err=1, no im_we for it; the next legal op lands at the next address with no gap.
//  ADDR_W=2, write 5 words -> addresses 0,1,2,3,0; wrapped=1 after the 4th write.
//  finish with 2 words queued -> FLUSH, writes both, then done=1. With ENC_HALT_APPEND_EN, a third write of 1000FFFF precedes done.
//  Bonus: rst asserted in FLUSH -> next cycle im_we=0, done=0, im_addr=0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic MIPS requests (add/sub/and/or/slt/addi/lw/sw/beq)
// into 32-bit words, buffers them in a small FIFO and writes them to instruction memory
// at sequential word addresses.
// Optional feature macro: ENC_HALT_APPEND_EN appends a halt word (beq $0,$0,-1) on finish.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, finish             start a load (clears addr/err/wrapped), end of requests
//   req_valid/req_ready       request handshake
//   req_op/rs/rt/rd/imm       symbolic instruction request
//   im_we/im_ready            instruction-memory write handshake
//   im_addr, im_wdata         write address and encoded word (FIFO head)
//   done, err, wrapped        load complete, sticky illegal op, sticky address wrap
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  output logic              im_we,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              done,
  output logic              err,
  output logic              wrapped
);

  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam logic [31:0] HALT_WORD = 32'h1000_FFFF;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  state_t             state;
  logic [31:0]        mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic               err_q;
  logic               wrapped_q;

  logic               full;
  logic               empty;
  logic               accept;
  logic               pop;
  logic               push;
  logic               halt_push;
  logic               halt_pend;
  logic [31:0]        enc_word;
  logic               enc_legal;
  logic [31:0]        push_word;
  logic [CNT_W-1:0]   cnt_after_pop;
  logic [CNT_W-1:0]   next_count;
  logic [PTR_W-1:0]   rd_next;
  logic [31:0]        head_next;

  // Status derived only from registered state, no input-to-output paths
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign req_ready = (state == S_LOAD) && !full;
  assign im_we     = !empty && ((state == S_LOAD) || (state == S_FLUSH));
  assign im_addr   = addr_q;
  assign im_wdata  = wdata_q;
  assign done      = (state == S_DONE);
  assign err       = err_q;
  assign wrapped   = wrapped_q;

  assign accept = req_valid && req_ready;
  assign pop    = im_we && im_ready;

  // Instruction encoder
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (req_op)
      4'd0:    enc_word = {6'h00, req_rs, req_rt, req_rd, 5'h00, 6'h20};
      4'd1:    enc_word = {6'h00, req_rs, req_rt, req_rd, 5'h00, 6'h22};
      4'd2:    enc_word = {6'h00, req_rs, req_rt, req_rd, 5'h00, 6'h24};
      4'd3:    enc_word = {6'h00, req_rs, req_rt, req_rd, 5'h00, 6'h25};
      4'd4:    enc_word = {6'h00, req_rs, req_rt, req_rd, 5'h00, 6'h2A};
      4'd5:    enc_word = {6'h08, req_rs, req_rt, req_imm};
      4'd6:    enc_word = {6'h23, req_rs, req_rt, req_imm};
      4'd7:    enc_word = {6'h2B, req_rs, req_rt, req_imm};
      4'd8:    enc_word = {6'h04, req_rs, req_rt, req_imm};
      default: enc_legal = 1'b0;
    endcase
  end

`ifdef ENC_HALT_APPEND_EN
  // Halt word goes in during FLUSH whenever there is room
  assign halt_push = halt_pend && (state == S_FLUSH) && !full;
`else
  assign halt_pend = 1'b0;
  assign halt_push = 1'b0;
`endif

  assign push      = (accept && enc_legal) || halt_push;
  assign push_word = halt_push ? HALT_WORD : enc_word;

  // Next FIFO head: a word pushed into an (effectively) empty FIFO becomes the head directly
  assign cnt_after_pop = count - CNT_W'(pop);
  assign next_count    = cnt_after_pop + CNT_W'(push);
  assign rd_next       = rd_ptr + PTR_W'(pop);
  assign head_next     = (cnt_after_pop == '0) ? push_word : mem[rd_next];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      wrapped_q <= 1'b0;
`ifdef ENC_HALT_APPEND_EN
      halt_pend <= 1'b0;
`endif
    end else if (start) begin
      // start wins over everything: flush and begin a fresh load
      state     <= S_LOAD;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      wrapped_q <= 1'b0;
`ifdef ENC_HALT_APPEND_EN
      halt_pend <= 1'b0;
`endif
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_next;
        addr_q <= addr_q + ADDR_W'(1);
        if (&addr_q) wrapped_q <= 1'b1;
      end
      count <= next_count;
      // Head word is held when the FIFO drains
      if (next_count != '0) wdata_q <= head_next;
      if (accept && !enc_legal) err_q <= 1'b1;
`ifdef ENC_HALT_APPEND_EN
      if (halt_push) halt_pend <= 1'b0;
`endif
      case (state)
        S_LOAD: begin
          if (finish) begin
            state <= S_FLUSH;
`ifdef ENC_HALT_APPEND_EN
            halt_pend <= 1'b1;
`endif
          end
        end
        S_FLUSH: begin
          if (empty && !halt_pend) state <= S_DONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed checks of encoding, FIFO back-pressure, illegal ops,
// address wrap (second instance with ADDR_W=2), finish/flush and reset mid-flush.
// Honours ENC_HALT_APPEND_EN for the expected flush contents.
module tb_instr_encoder_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        finish;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [15:0] req_imm;
  logic        im_we;
  logic        im_ready;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic        done;
  logic        err;
  logic        wrapped;

  logic        req_ready2;
  logic        im_we2;
  logic [1:0]  im_addr2;
  logic [31:0] im_wdata2;
  logic        done2;
  logic        err2;
  logic        wrapped2;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] wq_data  [$];
  logic [7:0]  wq_addr  [$];
  logic [1:0]  wq2_addr [$];

  logic [31:0] exp_t2 [4] = '{32'h20010005, 32'h8C220004, 32'hAC220008, 32'h1022FFFE};
  logic [31:0] exp_t3 [4] = '{32'h00220022, 32'h00220822, 32'h00221022, 32'h00221822};
  logic [1:0]  exp_t5 [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
    .done(done), .err(err), .wrapped(wrapped)
  );

  instr_encoder_loader #(.ADDR_W(2), .DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready2),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .im_we(im_we2), .im_ready(im_ready), .im_addr(im_addr2), .im_wdata(im_wdata2),
    .done(done2), .err(err2), .wrapped(wrapped2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-log of completed memory writes
  always @(posedge clk) begin
    if (!rst && im_we && im_ready) begin
      wq_data.push_back(im_wdata);
      wq_addr.push_back(im_addr);
    end
    if (!rst && im_we2 && im_ready) wq2_addr.push_back(im_addr2);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clear_log();
    wq_data.delete();
    wq_addr.delete();
    wq2_addr.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
  endtask

  // Present one request and hold it until accepted (bounded)
  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm);
    int unsigned waited;
    waited    = 0;
    req_op    = op;
    req_rs    = rs;
    req_rt    = rt;
    req_rd    = rd;
    req_imm   = imm;
    req_valid = 1'b1;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) check("send_ready_timeout", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int unsigned idx;
    int unsigned n_exp;
    rst = 1'b1; start = 1'b0; finish = 1'b0; req_valid = 1'b0;
    req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0; im_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_im_we",     32'(im_we),     32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_wrapped",   32'(wrapped),   32'd0);
    check("rst_im_addr",   32'(im_addr),   32'd0);
    check("rst_im_wdata",  im_wdata,       32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'd0);

    // T1: single ADD, latency 1
    im_ready = 1'b1;
    clear_log();
    pulse_start();
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    check("t1_im_we",    32'(im_we),   32'd1);
    check("t1_im_addr",  32'(im_addr), 32'd0);
    check("t1_im_wdata", im_wdata,     32'h00221820);
    @(negedge clk);
    check("t1_writes", 32'(wq_data.size()), 32'd1);

    // T2: I-type back-to-back
    clear_log();
    pulse_start();
    send(4'd5, 5'd0, 5'd1, 5'd0, 16'h0005);
    send(4'd6, 5'd1, 5'd2, 5'd0, 16'h0004);
    send(4'd7, 5'd1, 5'd2, 5'd0, 16'h0008);
    send(4'd8, 5'd1, 5'd2, 5'd0, 16'hFFFE);
    repeat (3) @(negedge clk);
    check("t2_writes", 32'(wq_data.size()), 32'd4);
    if (wq_data.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t2_data%0d", i), wq_data[i], exp_t2[i]);
        check($sformatf("t2_addr%0d", i), 32'(wq_addr[i]), 32'(i));
      end
    end

    // T3: back-pressure with im_ready low for 10 cycles
    clear_log();
    pulse_start();
    im_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      req_op = 4'd1; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'(idx); req_imm = '0;
      req_valid = 1'b1;
      if (req_ready) idx++;
      @(negedge clk);
      if (c == 5) check("t3_wdata_mid", im_wdata, exp_t3[0]);
    end
    req_valid = 1'b0;
    check("t3_accepts",   32'(idx),       32'd4);
    check("t3_req_ready", 32'(req_ready), 32'd0);
    check("t3_im_we",     32'(im_we),     32'd1);
    check("t3_im_addr",   32'(im_addr),   32'd0);
    check("t3_wdata_end", im_wdata,       exp_t3[0]);
    check("t3_no_writes", 32'(wq_data.size()), 32'd0);
    im_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("t3_writes", 32'(wq_data.size()), 32'd4);
    if (wq_data.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t3_data%0d", i), wq_data[i], exp_t3[i]);
        check($sformatf("t3_addr%0d", i), 32'(wq_addr[i]), 32'(i));
      end
    end
    check("t3_ready_again", 32'(req_ready), 32'd1);

    // T4: illegal op consumed, no address gap
    clear_log();
    pulse_start();
    send(4'd2, 5'd1, 5'd1, 5'd1, 16'h0);
    send(4'd9, 5'd7, 5'd7, 5'd7, 16'h1234);
    repeat (2) @(negedge clk);
    check("t4_err",     32'(err),              32'd1);
    check("t4_writes1", 32'(wq_data.size()),   32'd1);
    send(4'd3, 5'd3, 5'd4, 5'd5, 16'h0);
    repeat (2) @(negedge clk);
    check("t4_writes2", 32'(wq_data.size()), 32'd2);
    if (wq_data.size() == 2) begin
      check("t4_data0", wq_data[0],       32'h00210824);
      check("t4_data1", wq_data[1],       32'h00642825);
      check("t4_addr1", 32'(wq_addr[1]),  32'd1);
    end

    // T5: address wrap on the ADDR_W=2 instance
    clear_log();
    pulse_start();
    check("t5_err_cleared", 32'(err), 32'd0);
    for (int i = 0; i < 3; i++) send(4'd4, 5'd0, 5'd0, 5'(i), 16'h0);
    repeat (2) @(negedge clk);
    check("t5_wrapped_3", 32'(wrapped2), 32'd0);
    send(4'd4, 5'd0, 5'd0, 5'd3, 16'h0);
    repeat (2) @(negedge clk);
    check("t5_wrapped_4", 32'(wrapped2), 32'd1);
    send(4'd4, 5'd0, 5'd0, 5'd4, 16'h0);
    repeat (2) @(negedge clk);
    check("t5_wide_nowrap", 32'(wrapped), 32'd0);
    check("t5_writes", 32'(wq2_addr.size()), 32'd5);
    if (wq2_addr.size() == 5) begin
      for (int i = 0; i < 5; i++)
        check($sformatf("t5_addr%0d", i), 32'(wq2_addr[i]), 32'(exp_t5[i]));
    end

    // T6: finish with two words queued
    clear_log();
    pulse_start();
    im_ready = 1'b0;
    send(4'd5, 5'd2, 5'd3, 5'd0, 16'h0010);
    send(4'd5, 5'd2, 5'd3, 5'd0, 16'h0020);
    pulse_finish();
    check("t6_req_ready", 32'(req_ready), 32'd0);
    check("t6_done_early", 32'(done), 32'd0);
    im_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      @(negedge clk);
    end
`ifdef ENC_HALT_APPEND_EN
    n_exp = 3;
`else
    n_exp = 2;
`endif
    check("t6_done",   32'(done),  32'd1);
    check("t6_im_we",  32'(im_we), 32'd0);
    check("t6_writes", 32'(wq_data.size()), 32'(n_exp));
    if (wq_data.size() == n_exp) begin
      check("t6_data0", wq_data[0], 32'h20430010);
      check("t6_data1", wq_data[1], 32'h20430020);
      if (n_exp == 3) begin
        check("t6_halt",      wq_data[2],      32'h1000FFFF);
        check("t6_halt_addr", 32'(wq_addr[2]), 32'd2);
      end
    end

    // T7: reset during FLUSH
    clear_log();
    pulse_start();
    im_ready = 1'b0;
    send(4'd7, 5'd0, 5'd5, 5'd0, 16'h0010);
    send(4'd7, 5'd0, 5'd5, 5'd0, 16'h0014);
    pulse_finish();
    im_ready = 1'b1;
    @(negedge clk);
    im_ready = 1'b0;
    check("t7_pre_addr", 32'(im_addr), 32'd1);
    check("t7_pre_we",   32'(im_we),   32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t7_im_we",     32'(im_we),     32'd0);
    check("t7_done",      32'(done),      32'd0);
    check("t7_im_addr",   32'(im_addr),   32'd0);
    check("t7_im_wdata",  im_wdata,       32'h0);
    check("t7_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t7_idle_we",   32'(im_we), 32'd0);
    check("t7_idle_done", 32'(done),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
